simd_lane_pipe: RTL and testbench



---
 rtl/simd_lane_pipe_if.sv | 33 +++
 rtl/simd_lane_pipe.sv | 115 +++++++++++
 tb/tb_simd_lane_pipe.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_lane_pipe_if.sv
// simd_lane_pipe_if: operand in / result out channel bundle
// for the SIMD lane pipe (driver side = master, pipe side = slave).
interface simd_lane_pipe_if #(
  parameter int DWIDTH      = 64,
  parameter int SIMD_DEGREE = 8,
  parameter int CNT_W       = 32
);
  logic                          in_valid;
  logic                          in_ready;
  logic [1:0]                    in_op;
  logic [SIMD_DEGREE*DWIDTH-1:0] in_a;
  logic [SIMD_DEGREE*DWIDTH-1:0] in_b;
  logic                          in_last;
  logic                          out_valid;
  logic                          out_ready;
  logic [SIMD_DEGREE*DWIDTH-1:0] out_data;
  logic                          out_last;
  logic [SIMD_DEGREE-1:0]        out_sat;
  logic [CNT_W-1:0]              beat_count;
  logic [CNT_W-1:0]              pkt_count;

  modport master (
    output in_valid, in_op, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_sat,
    input  beat_count, pkt_count
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_sat,
    output beat_count, pkt_count
  );
endinterface

// File: rtl/simd_lane_pipe.sv
// simd_lane_pipe: fixed-latency SIMD lane ALU (ADD/SUB/MAX/PASS).
// Optional SATURATE_EN: clamp signed ADD/SUB overflow, flag per lane.
module simd_lane_pipe #(
  parameter int DWIDTH      = 64,
  parameter int SIMD_DEGREE = 8,
  parameter int LATENCY     = 4,
  parameter int CNT_W       = 32
) (
  input  logic            clk,
  input  logic            rst,
  simd_lane_pipe_if.slave bus
);
  localparam int W = SIMD_DEGREE * DWIDTH;
  localparam int M = DWIDTH - 1;

  logic                   adv;
  logic [LATENCY-1:0]     vld;
  logic [LATENCY-1:0]     lst;
  logic [W-1:0]           dat [LATENCY];
  logic [SIMD_DEGREE-1:0] sat [LATENCY];
  logic [W-1:0]           alu_d;
  logic [SIMD_DEGREE-1:0] alu_s;
  logic [CNT_W-1:0]       beats;
  logic [CNT_W-1:0]       pkts;

  function automatic logic [DWIDTH:0] lane_op(
    input logic [1:0]        op,
    input logic [DWIDTH-1:0] a,
    input logic [DWIDTH-1:0] b
  );
    logic [DWIDTH-1:0] s;
    logic [DWIDTH-1:0] d;
    logic [DWIDTH-1:0] r;
    logic              f;
`ifdef SATURATE_EN
    logic              ovf;
`endif
    s = a + b;
    d = a - b;
    r = a;
    f = 1'b0;
    unique case (1'b1)
      op == 2'b00: r = s;
      op == 2'b01: r = d;
      op == 2'b10: r = ($signed(a) > $signed(b)) ? a : b;
      op == 2'b11: r = a;
    endcase
`ifdef SATURATE_EN
    ovf = (op == 2'b00 && a[M] == b[M] && s[M] != a[M]) ||
          (op == 2'b01 && a[M] != b[M] && d[M] != a[M]);
    if (ovf) begin
      f = 1'b1;
      r = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
    end
`endif
    return {f, r};
  endfunction

  // Whole pipe moves together; stalls only when the head is blocked.
  assign adv          = !vld[LATENCY-1] || bus.out_ready;
  assign bus.in_ready = adv;

  assign bus.out_valid  = vld[LATENCY-1];
  assign bus.out_last   = lst[LATENCY-1];
  assign bus.out_data   = vld[LATENCY-1] ? dat[LATENCY-1] : '0;
  assign bus.out_sat    = vld[LATENCY-1] ? sat[LATENCY-1] : '0;
  assign bus.beat_count = beats;
  assign bus.pkt_count  = pkts;

  // Per-lane ALU feeding stage 1.
  always_comb begin
    alu_d = '0;
    alu_s = '0;
    for (int i = 0; i < SIMD_DEGREE; i++) begin
      {alu_s[i], alu_d[i*DWIDTH +: DWIDTH]} =
        lane_op(bus.in_op,
                bus.in_a[i*DWIDTH +: DWIDTH],
                bus.in_b[i*DWIDTH +: DWIDTH]);
    end
  end

  // Stage registers: load stage 1 from ALU, shift the rest on advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      lst <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        dat[i] <= '0;
        sat[i] <= '0;
      end
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      lst[0] <= bus.in_valid && bus.in_last;
      dat[0] <= alu_d;
      sat[0] <= alu_s;
      for (int i = 1; i < LATENCY; i++) begin
        vld[i] <= vld[i-1];
        lst[i] <= lst[i-1];
        dat[i] <= dat[i-1];
        sat[i] <= sat[i-1];
      end
    end
  end

  // Delivered beat / packet counters, wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beats <= '0;
      pkts  <= '0;
    end else if (vld[LATENCY-1] && bus.out_ready) begin
      beats <= beats + 1'b1;
      if (lst[LATENCY-1]) pkts <= pkts + 1'b1;
    end
  end
endmodule

// File: tb/tb_simd_lane_pipe.sv
// tb_simd_lane_pipe: random + directed bench for simd_lane_pipe
// against an arithmetic reference model and beat scoreboard.
module tb_simd_lane_pipe;
  localparam int DW  = 64;
  localparam int SD  = 8;
  localparam int LAT = 4;
  localparam int CW  = 4;
  localparam int W   = DW * SD;

  localparam logic signed [DW:0] HI = {2'b00, {(DW-1){1'b1}}};
  localparam logic signed [DW:0] LO = {2'b11, {(DW-1){1'b0}}};

  typedef struct {
    logic [W-1:0]  d;
    logic [SD-1:0] s;
    logic          l;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    eb = 0;
  int    ep = 0;
  bit    rnd = 1'b0;
  beat_t sb[$];
  beat_t mexp;

  simd_lane_pipe_if #(.DWIDTH(DW), .SIMD_DEGREE(SD), .CNT_W(CW)) bus();

  simd_lane_pipe #(
    .DWIDTH(DW), .SIMD_DEGREE(SD), .LATENCY(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic beat_t ref_beat(input logic [1:0] op,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b,
                                     input logic l);
    beat_t r;
    logic signed [DW:0] x, y, z;
    r.d = '0;
    r.s = '0;
    r.l = l;
    for (int i = 0; i < SD; i++) begin
      x = $signed(a[i*DW +: DW]);
      y = $signed(b[i*DW +: DW]);
      case (op)
        2'd0:    z = x + y;
        2'd1:    z = x - y;
        2'd2:    z = (x > y) ? x : y;
        default: z = x;
      endcase
`ifdef SATURATE_EN
      if (z > HI) begin
        z = HI;
        r.s[i] = 1'b1;
      end else if (z < LO) begin
        z = LO;
        r.s[i] = 1'b1;
      end
`endif
      r.d[i*DW +: DW] = z[DW-1:0];
    end
    return r;
  endfunction

  // Scoreboard: counters, idle zeroing, in-order result check.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      eb = 0;
      ep = 0;
    end else begin
      chk("beat_cnt", bus.beat_count, eb % (1 << CW));
      chk("pkt_cnt", bus.pkt_count, ep % (1 << CW));
      if (!bus.out_valid) chk("idle_data", bus.out_data, '0);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          mexp = sb.pop_front();
          chk("data", bus.out_data, mexp.d);
          chk("sat", bus.out_sat, mexp.s);
          chk("last", bus.out_last, mexp.l);
        end
        eb++;
        if (bus.out_last) ep++;
      end
      if (bus.in_valid && bus.in_ready)
        sb.push_back(ref_beat(bus.in_op, bus.in_a, bus.in_b,
                              bus.in_last));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (rnd) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic l);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = l;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.in_ready;
      tick();
    end
    if (!ok) chk("send_timeout", 1, 0);
  endtask

  task automatic idle(input int k);
    bus.in_valid = 1'b0;
    repeat (k) tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    bus.in_valid  = 1'b0;
    rnd           = 1'b0;
    bus.out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    tick();
    chk("drain", sb.size(), 0);
  endtask

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    logic [DW-1:0] e;
    for (int i = 0; i < SD; i++) begin
      case ($urandom_range(0, 7))
        0: e = {1'b0, {(DW-1){1'b1}}};
        1: e = {1'b1, {(DW-1){1'b0}}};
        2: e = '1;
        3: e = 1;
        default: e = {$urandom, $urandom};
      endcase
      v[i*DW +: DW] = e;
    end
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    int n, c0, c1, nv, p0;
    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_bc", bus.beat_count, 0);
    chk("rst_pc", bus.pkt_count, 0);
    chk("rst_rdy", bus.in_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single ADD beat, latency and result
    a = W'(5);
    b = W'(7);
    send(2'b00, a, b, 1'b1);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", n, LAT - 1);
    chk("lane0_add", bus.out_data[DW-1:0], 12);
    tick();
    chk("bc_one", bus.beat_count, 1);
    drain();

    // 16 back-to-back beats cycling ops
    a  = {SD{64'hFFFF_FFFF_FFFF_FFFD}};
    b  = {SD{64'd10}};
    p0 = ep;
    for (int k = 0; k < 16; k++) begin
      send(2'(k % 4), a, b, k == 15);
      if (k == 0) c0 = cyc;
      if (k == 15) c1 = cyc;
    end
    chk("throughput", c1 - c0, 15);
    drain();
    chk("pkt_after16", bus.pkt_count, (p0 + 1) % (1 << CW));

    // stall with full pipe
    bus.out_ready = 1'b0;
    for (int k = 0; k < LAT; k++)
      send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), 1'b0);
    a = rnd_vec();
    b = rnd_vec();
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b01;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("stall_rdy", bus.in_ready, 0);
      chk("stall_ov", bus.out_valid, 1);
      if (sb.size() != 0) chk("stall_data", bus.out_data, sb[0].d);
      tick();
    end
    bus.out_ready = 1'b1;
    send(2'b01, a, b, 1'b1);
    drain();

    // signed overflow on lane 2
    a = '0;
    b = '0;
    a[2*DW +: DW] = {1'b0, {(DW-1){1'b1}}};
    b[2*DW +: DW] = 1;
    send(2'b00, a, b, 1'b0);
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
`ifdef SATURATE_EN
    chk("ovf_data", bus.out_data[2*DW +: DW], {1'b0, {(DW-1){1'b1}}});
    chk("ovf_sat", bus.out_sat, 8'b0000_0100);
`else
    chk("ovf_data", bus.out_data[2*DW +: DW], {1'b1, {(DW-1){1'b0}}});
    chk("ovf_sat", bus.out_sat, 0);
`endif
    drain();

    // reset mid-packet with beats in flight
    for (int k = 0; k < 5; k++)
      send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_ov", bus.out_valid, 0);
    chk("mrst_data", bus.out_data, '0);
    chk("mrst_sat", bus.out_sat, 0);
    chk("mrst_last", bus.out_last, 0);
    chk("mrst_bc", bus.beat_count, 0);
    chk("mrst_pc", bus.pkt_count, 0);
    chk("mrst_rdy", bus.in_ready, 1);
    tick();
    tick();
    rst = 1'b0;
    nv = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) nv++;
      tick();
    end
    chk("stale_beats", nv, 0);
    chk("post_bc", bus.beat_count, 0);

    // counter wrap: 17 beats on a 4-bit counter
    for (int k = 0; k < 17; k++)
      send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(), k == 16);
    drain();
    chk("wrap_bc", bus.beat_count, 1);
    chk("wrap_pc", bus.pkt_count, 1);

    // random traffic with random backpressure
    rnd = 1'b1;
    for (int k = 0; k < 300; k++) begin
      send(2'($urandom_range(0, 3)), rnd_vec(), rnd_vec(),
           $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
